mnist_frame_streamer: RTL
=========================

# mnist_frame_streamer

Host-side transmitter for the CNN byte-stream interface. It buffers one 28x28 MNIST frame, then serializes it as pixel bytes, plus a label byte in training mode, onto the accelerator's `usb_data_in`/`usb_data_valid` input. It then waits for the classification byte returned on `usb_data_out`/`usb_data_ready`. It sits between the test/host logic and the CNN top and is the other end of that interface.

## Interface
- `IMAGE_PIXELS`, 784, number of pixel bytes per frame.
- `ADDR_W`, 10, frame-buffer address width; must satisfy 2^ADDR_W >= IMAGE_PIXELS.
- `TIMEOUT_CYCLES`, 4096, maximum cycles spent waiting for a result.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  1  frame-buffer write strobe.
- `wr_addr`  in  ADDR_W  frame-buffer write address.
- `wr_data`  in  8  pixel byte to write.
- `start`  in  1  begin streaming the buffered frame.
- `mode_train`  in  1  1 = append the label byte; sampled at `start`.
- `label_in`  in  8  label byte; sampled at `start`.
- `busy`  out  1  high in every state except IDLE.
- `tx_data`  out  8  byte to the CNN (drives `usb_data_in`).
- `tx_valid`  out  1  `tx_data` is valid (drives `usb_data_valid`).
- `tx_ready`  in  1  downstream accepts the byte this cycle.
- `rx_data`  in  8  result byte (from `usb_data_out`).
- `rx_valid`  in  1  result strobe (from `usb_data_ready`).
- `result`  out  8  last captured classification byte.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `timeout`  out  1  one-cycle pulse when the result wait expires.

## Operation
- **States:** IDLE, SEND_PIX, SEND_LABEL, SEND_CSUM (only with the macro), WAIT_RES.
- **Frame buffer:** IMAGE_PIXELS x 8 bits.
  - `wr_en` writes it only in IDLE; writes while `busy` are dropped.
  - Addresses >= IMAGE_PIXELS are ignored.
- **IDLE:**
  - `start` latches `mode_train` and `label_in`, clears the pixel index and checksum, and enters SEND_PIX.
  - `start` while `busy` is ignored.
- **Transfer rule:** a byte transfers on a cycle where `tx_valid && tx_ready`.
  - While `tx_valid` is high and `tx_ready` is low, `tx_data` must hold stable.
  - `tx_valid` never drops without a transfer, except on reset.
- **SEND_PIX:** sends buffer[0..IMAGE_PIXELS-1] in order. After the last pixel transfers:
  - if the latched `mode_train` = 1, go to SEND_LABEL;
  - otherwise go to SEND_CSUM (with macro) or WAIT_RES.
- **SEND_LABEL:** sends the latched label, then goes to SEND_CSUM or WAIT_RES.
- **WAIT_RES:**
  - `tx_valid` = 0.
  - A wait counter starts at 0 on entry and increments every cycle.
  - `rx_valid` captures `rx_data` into `result`, pulses `result_valid`, and returns to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no `rx_valid`: pulse `timeout`, leave `result` unchanged, return to IDLE.
  - If `rx_valid` and the timeout terminal count occur in the same cycle, the result wins and `timeout` does not pulse.
- `rx_valid` outside WAIT_RES is ignored.
- **Reset (any time, including mid-frame):**
  - state goes to IDLE;
  - `tx_valid`, `busy`, `result_valid` and `timeout` go to 0;
  - `tx_data` = 0 and `result` = 0;
  - frame-buffer contents are not cleared.

## Timing
- `start` sampled in cycle N → `busy` = 1 and `tx_valid` = 1 with pixel 0 in cycle N+1.
- **Throughput:** one byte per cycle with `tx_ready` held high.
  - Inference frame: 784 consecutive `tx_valid` cycles.
  - Training frame: 785 consecutive cycles (plus 1 with the checksum macro).
- After a transfer, the next byte appears in the following cycle with no bubble. Buffer read is combinational on the index, and `tx_data` is registered.
- `rx_valid` in WAIT_RES cycle M → `result` updated and `result_valid` = 1 in cycle M+1. `busy` = 0 in M+1.
- `timeout` pulse and `busy` deassertion occur in the same cycle.
- All outputs are registered.

## Configuration
- **Macro:** `STREAM_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit XOR of every transferred byte (pixels, plus the label if sent) is accumulated.
  - After the last data byte, SEND_CSUM transmits that checksum as one extra byte under the same handshake.
- **Undefined:** SEND_CSUM and the accumulator are absent. The last data byte transitions directly to WAIT_RES.

## Test plan
- **Inference frame:** buffer[i] = i[7:0], `mode_train` = 0, `tx_ready` = 1 → 784 bytes 0x00,0x01,…,0x0F (index 783 & 0xFF) back-to-back. `rx_valid` with 0x07 → `result` = 0x07 and a one-cycle `result_valid`.
- **Training frame:** `mode_train` = 1, `label_in` = 0x05 → the byte after pixel 783 is 0x05. With `STREAM_CHECKSUM_EN`, the next byte is the XOR of all 785 bytes.
- **Backpressure:** toggle `tx_ready` pseudo-randomly → the receiver sees exactly the buffer sequence, and `tx_data` never changes while stalled.
- **Timeout:** TIMEOUT_CYCLES = 16, no `rx_valid` → `timeout` pulses 16 cycles after WAIT_RES entry and `result` keeps its prior value. The timeout-vs-`rx_valid` collision case → `result_valid` only.
- **Ignored inputs:** `start` and `wr_en` while `busy` → no restart and no buffer change. `rx_valid` during SEND_PIX → ignored.
- **Mid-frame reset:** assert `rst` at pixel 300 → `tx_valid` = 0 and IDLE immediately. A new `start` resends from pixel 0 with the buffer intact.

Source files
------------

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: buffers one MNIST frame and streams it (plus optional label) to the CNN, then waits for the result byte.
// Optional feature: define STREAM_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
`timescale 1ns/1ps
module mnist_frame_streamer #(
  parameter int IMAGE_PIXELS   = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              mode_train,
  input  logic [7:0]        label_in,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        result,
  output logic              result_valid,
  output logic              timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef STREAM_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SEND_PIX, SEND_LABEL, SEND_CSUM, WAIT_RES} state_t;
  logic [7:0] csum;
  logic [7:0] csum_nxt;
  assign csum_nxt = csum ^ tx_data;
`else
  typedef enum logic [2:0] {IDLE, SEND_PIX, SEND_LABEL, WAIT_RES} state_t;
`endif
  logic [7:0]        mem [IMAGE_PIXELS];
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] nxt;
  logic [CW-1:0]     cnt;
  logic              train;
  logic [7:0]        label;
  logic              xfer;
  logic              last_pix;
  assign xfer     = tx_valid && tx_ready;
  assign nxt      = idx + 1'b1;
  assign last_pix = idx == ADDR_W'(IMAGE_PIXELS - 1);
  // Frame buffer: host writes land only while idle and in range; contents survive reset
  always_ff @(posedge clk)
    if (wr_en && !busy && wr_addr < ADDR_W'(IMAGE_PIXELS)) mem[wr_addr] <= wr_data;
  // Streaming FSM: tx_data is preloaded so a new byte follows every transfer without a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      train        <= 1'b0;
      label        <= '0;
`ifdef STREAM_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state    <= SEND_PIX;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= mem[ADDR_W'(0)];
            idx      <= '0;
            train    <= mode_train;
            label    <= label_in;
`ifdef STREAM_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        SEND_PIX:
          if (xfer) begin
`ifdef STREAM_CHECKSUM_EN
            csum <= csum_nxt;
`endif
            if (!last_pix) begin
              idx     <= nxt;
              tx_data <= mem[nxt];
            end else if (train) begin
              state   <= SEND_LABEL;
              tx_data <= label;
            end else begin
`ifdef STREAM_CHECKSUM_EN
              state   <= SEND_CSUM;
              tx_data <= csum_nxt;
`else
              state    <= WAIT_RES;
              tx_valid <= 1'b0;
              cnt      <= '0;
`endif
            end
          end
        SEND_LABEL:
          if (xfer) begin
`ifdef STREAM_CHECKSUM_EN
            csum    <= csum_nxt;
            state   <= SEND_CSUM;
            tx_data <= csum_nxt;
`else
            state    <= WAIT_RES;
            tx_valid <= 1'b0;
            cnt      <= '0;
`endif
          end
`ifdef STREAM_CHECKSUM_EN
        SEND_CSUM:
          if (xfer) begin
            state    <= WAIT_RES;
            tx_valid <= 1'b0;
            cnt      <= '0;
          end
`endif
        WAIT_RES:
          if (rx_valid) begin
            result       <= rx_data;
            result_valid <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
endmodule
